contador_secuenciador: RTL
==========================

Name: contador_secuenciador

Overview:
- Upstream command stage for the 4-bit mode counter (ENB/MODO/D in, Q/RCO out).
- Accepts commands {MODO, D, CICLOS} over a valid/ready interface and buffers them in a small FIFO.
- Executes each command by driving ENB/MODO/D for exactly CICLOS clock cycles.
- Reports completion with a one-cycle DONE pulse, the captured final Q, and the count of RCO samples seen during the command.

Parameters:
PROF, 4, FIFO depth in commands; power of 2, minimum 2
ANCHO_CICLOS, 8, width of the per-command cycle count

Ports:
CLK  input  1  single clock; all logic on rising edge
RESET  input  1  synchronous, active-high reset
CMD_VALID  input  1  command present on CMD_* this cycle
CMD_READY  output  1  FIFO can accept; push = CMD_VALID & CMD_READY
CMD_MODO  input  2  counter mode for the command
CMD_D  input  4  load data for the command
CMD_CICLOS  input  ANCHO_CICLOS  cycles with ENB=1 (0 = no-op command)
ENB  output  1  to counter enable
MODO  output  2  to counter mode
D  output  4  to counter data
Q  input  4  counter state (registered in counter)
RCO  input  1  counter ripple carry
BUSY  output  1  state != IDLE or FIFO non-empty
DONE  output  1  one-cycle pulse at command end
DONE_Q  output  4  Q captured at command end; held until next DONE
RCO_CNT  output  8  RCO=1 samples during last command, saturating at 255; held until next DONE

Behaviour:
- Reset (RESET=1 at an edge):
  - FIFO flushed; state = IDLE.
  - ENB, MODO, D, DONE, DONE_Q, RCO_CNT, BUSY all 0.
  - CMD_READY = 0 while RESET is high; CMD_READY = 1 in the first cycle after release.
  - Reset has priority over everything, including mid-RUN: ENB = 0 from the next cycle.
- FIFO:
  - CMD_READY = !full, registered state; there is no same-cycle bypass when full.
  - A push on an empty FIFO is not poppable until the following cycle (no fall-through).
  - A push and a pop in the same cycle are both legal.
  - A push while full is impossible, because READY is low.
  - Pointers are log2(PROF) bits with an extra wrap bit to distinguish full from empty.
- States:
  - IDLE:
    - ENB = 0; MODO and D hold their last values.
    - If FIFO non-empty: pop the head into working registers (modo_r, d_r, cnt_r = CICLOS); clear the RCO accumulator.
    - Then go to RUN if CICLOS != 0, else to FIN.
  - RUN:
    - ENB = 1, MODO = modo_r, D = d_r, all registered.
    - Each cycle: accumulator += RCO, saturating at 255; cnt_r decrements.
    - When cnt_r reaches 1, the next state is FIN.
    - RUN therefore lasts exactly CICLOS cycles.
  - FIN (exactly one cycle):
    - ENB = 0; DONE = 1; DONE_Q <= Q; RCO_CNT <= accumulator.
    - Then IDLE.
- Timing:
  - Command overhead is 2 cycles (IDLE pop + FIN).
  - Back-to-back commands: ENB drops for the FIN and IDLE cycles.
- Q and RCO handling:
  - Q is sampled in FIN, so it reflects the last ENB=1 edge.
  - RCO is sampled only in RUN; RCO in IDLE and FIN is ignored.
- Widths: CMD_CICLOS is an unsigned count; no arithmetic wraps except the FIFO pointers.

Test Plan:
- Reset: assert RESET 3 cycles mid-stream -> all outputs 0 and CMD_READY=0 during reset; CMD_READY=1 the cycle after release; BUSY=0.
- Load then count: push {11, 1010, 1} then {00, xxxx, 5} against the counter model -> ENB high 1 cycle, DONE_Q=1010; then ENB high 5 cycles, DONE_Q=1111, RCO_CNT=0.
- Overflow count: from Q=0000 push {00, 0000, 20} -> ENB high exactly 20 cycles, DONE_Q=0100, RCO_CNT=1, DONE a single-cycle pulse.
- Backpressure: push 6 commands {00, 0, 10} with CMD_VALID held high -> 5 accepted (1 popped + 4 stored), READY low until the next IDLE pop, 6th accepted then; 6 DONE pulses, each 12 cycles apart.
- No-op: push {01, 0011, 0} -> ENB never asserted, DONE pulses 2 cycles after pop, DONE_Q equals the current Q, RCO_CNT=0.
- Reset mid-RUN: pulse RESET at RUN cycle 3 of a 10-cycle command with 2 commands queued -> ENB=0 next cycle, no DONE, FIFO empty, BUSY=0.

Source files
------------

// File: rtl/contador_secuenciador_if.sv
// rtl/contador_secuenciador_if.sv - command handshake bundle for contador_secuenciador
// Ports:
//   cmd_valid  : a command is present on cmd_modo/cmd_d/cmd_ciclos this cycle
//   cmd_ready  : the sequencer can accept; a push happens on cmd_valid & cmd_ready
//   cmd_modo   : counter mode to apply while the command runs
//   cmd_d      : counter load data to apply while the command runs
//   cmd_ciclos : number of cycles with enb=1 (0 makes the command a no-op)
interface contador_secuenciador_if #(
  parameter int ANCHO_CICLOS = 8
);
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic [1:0]              cmd_modo;
  logic [3:0]              cmd_d;
  logic [ANCHO_CICLOS-1:0] cmd_ciclos;

  modport master (
    output cmd_valid,
    output cmd_modo,
    output cmd_d,
    output cmd_ciclos,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_modo,
    input  cmd_d,
    input  cmd_ciclos,
    output cmd_ready
  );
endinterface

// File: rtl/contador_secuenciador.sv
// rtl/contador_secuenciador.sv - command FIFO and sequencer driving the 4-bit mode counter
// Ports:
//   clk, reset : single rising-edge clock, synchronous active-high reset
//   cmd        : command handshake (slave side), buffered in a PROF-deep FIFO
//   enb/modo/d : registered drive to the counter's enable, mode and data inputs
//   q, rco     : counter state and ripple carry fed back from the counter
//   busy       : a command is in flight or waiting in the FIFO
//   done       : one-cycle pulse when a command has finished
//   done_q     : counter state captured at command end, held until the next done
//   rco_cnt    : rco samples seen while the command ran (saturating), held until the next done
module contador_secuenciador #(
  parameter int PROF         = 4,
  parameter int ANCHO_CICLOS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  contador_secuenciador_if.slave  cmd,
  output logic                    enb,
  output logic [1:0]              modo,
  output logic [3:0]              d,
  input  logic [3:0]              q,
  input  logic                    rco,
  output logic                    busy,
  output logic                    done,
  output logic [3:0]              done_q,
  output logic [7:0]              rco_cnt
);
  localparam int AW = $clog2(PROF);
  localparam int CW = ANCHO_CICLOS;
  localparam int EW = 2 + 4 + CW;

  typedef enum logic [1:0] {IDLE, RUN, FIN} estado_t;

  logic [EW-1:0] mem [PROF];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic [EW-1:0] head;
  logic [1:0]    head_modo;
  logic [3:0]    head_d;
  logic [CW-1:0] head_ciclos;

  estado_t       estado;
  logic [CW-1:0] cnt_r;
  logic [7:0]    acc;

  // The extra top pointer bit separates full (same index, different lap) from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // Ready comes only from registered FIFO state, so a full FIFO never accepts even
  // when the sequencer pops in the same cycle; reset forces it low immediately.
  assign cmd.cmd_ready = !full && !reset;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign pop           = (estado == IDLE) && !empty;
  assign busy          = (estado != IDLE) || !empty;

  assign head        = mem[rd_ptr[AW-1:0]];
  assign head_modo   = head[EW-1 -: 2];
  assign head_d      = head[CW +: 4];
  assign head_ciclos = head[CW-1:0];

  // Storage carries no reset: entries are only read behind a valid pointer pair.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd.cmd_modo, cmd.cmd_d, cmd.cmd_ciclos};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // modo/d double as the working registers of the popped command: they are loaded
  // at the pop and held through RUN, FIN and the following IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado  <= IDLE;
      enb     <= 1'b0;
      modo    <= 2'd0;
      d       <= 4'd0;
      done    <= 1'b0;
      done_q  <= 4'd0;
      rco_cnt <= 8'd0;
      cnt_r   <= '0;
      acc     <= 8'd0;
    end else begin
      done <= 1'b0;
      case (estado)
        IDLE: begin
          enb <= 1'b0;
          if (!empty) begin
            cnt_r <= head_ciclos;
            acc   <= 8'd0;
            modo  <= head_modo;
            d     <= head_d;
            if (head_ciclos != '0) begin
              estado <= RUN;
              enb    <= 1'b1;
            end else begin
              estado <= FIN;
            end
          end
        end
        RUN: begin
          acc   <= (acc == 8'hff) ? acc : acc + 8'(rco);
          cnt_r <= cnt_r - CW'(1);
          if (cnt_r == CW'(1)) begin
            estado <= FIN;
            enb    <= 1'b0;
          end
        end
        FIN: begin
          // Counter was last enabled at the RUN->FIN edge, so q is final here.
          done    <= 1'b1;
          done_q  <= q;
          rco_cnt <= acc;
          estado  <= IDLE;
        end
        default: begin
          estado <= IDLE;
          enb    <= 1'b0;
        end
      endcase
    end
  end
endmodule
